// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Bundles the store-buffer request, load-check and DM-drain signals.
//   master : pipeline / DM side (drives st_*, ld_*, dm_busy)
//   slave  : store_buffer (drives st_ready, ld_stall/hit/fwd_data, dm_*, count, empty)
// Parameter PTR_W sets the width of count (PTR_W+1 bits).
interface store_buffer_if #(
  parameter int PTR_W = 2
);
  // store request from MEM stage
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [2:0]       st_op;
  logic [31:0]      st_pc;
  logic             st_ready;
  // load overlap check
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [2:0]       ld_op;
  logic             ld_stall;
  logic             ld_hit;
  logic [31:0]      ld_fwd_data;
  // DM write port
  logic             dm_busy;
  logic             dm_wr;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wd;
  logic [2:0]       dm_op;
  logic [31:0]      dm_pc;
  // occupancy
  logic [PTR_W:0]   count;
  logic             empty;

  modport master (
    output st_valid, st_addr, st_data, st_op, st_pc,
    output ld_valid, ld_addr, ld_op,
    output dm_busy,
    input  st_ready, ld_stall, ld_hit, ld_fwd_data,
    input  dm_wr, dm_addr, dm_wd, dm_op, dm_pc,
    input  count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_op, st_pc,
    input  ld_valid, ld_addr, ld_op,
    input  dm_busy,
    output st_ready, ld_stall, ld_hit, ld_fwd_data,
    output dm_wr, dm_addr, dm_wd, dm_op, dm_pc,
    output count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer
//   FIFO write buffer between the MEM-stage store path and DM. Accepts one
//   store per cycle, retires one per cycle into DM whenever DM is not serving
//   a load, and stalls loads that overlap a pending store.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset (discards all pending stores)
//   sb    : store_buffer_if.slave (store request, load check, DM drain, count/empty)
// Parameters: DEPTH (power of two, >=2), PTR_W = log2(DEPTH).
// Build option: define SB_FWD_EN to forward fully covered loads from the
//   youngest overlapping entry instead of stalling them.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave sb
);

  // Access-width codes shared with the pipeline's op encoding.
  localparam logic [2:0] OP_WORD = 3'd0;
  localparam logic [2:0] OP_HALF = 3'd1;
  localparam logic [2:0] OP_BITE = 3'd2;

  // Byte-lane mask of an access; zero for an unknown op.
  function automatic logic [3:0] byte_mask(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_WORD: byte_mask = 4'b1111;
      OP_HALF: byte_mask = a[1] ? 4'b1100 : 4'b0011;
      OP_BITE: byte_mask = 4'b0001 << a;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [2:0]       op_q   [DEPTH];
  logic [2:0]       op_d   [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [3:0]       mask_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [3:0]       st_mask;
  logic [3:0]       ld_mask;
  logic             is_empty;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] overlap_vec;
  logic             hit;

  assign st_mask  = byte_mask(sb.st_op, sb.st_addr[1:0]);
  assign ld_mask  = byte_mask(sb.ld_op, sb.ld_addr[1:0]);
  assign is_empty = (count_q == '0);

  // No bypass when full: a pop in the same cycle does not free a slot for the push.
  assign sb.st_ready = (count_q != (PTR_W+1)'(DEPTH));
  // Unknown ops are handshaken but never written.
  assign push = sb.st_valid && sb.st_ready && (st_mask != 4'b0000);
  assign pop  = !is_empty && !sb.dm_busy;

  assign sb.dm_wr   = pop;
  // Gating on the head valid bit keeps the DM bus at zero while empty or in reset.
  assign sb.dm_addr = valid_q[head_q] ? addr_q[head_q] : 32'h0;
  assign sb.dm_wd   = valid_q[head_q] ? data_q[head_q] : 32'h0;
  assign sb.dm_op   = valid_q[head_q] ? op_q[head_q]   : 3'h0;
  assign sb.dm_pc   = valid_q[head_q] ? pc_q[head_q]   : 32'h0;
  assign sb.count   = count_q;
  assign sb.empty   = is_empty;

  // Per-entry overlap; the entry draining this cycle is still valid here.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ovl
    assign overlap_vec[gi] = valid_q[gi]
                          && (addr_q[gi][31:2] == sb.ld_addr[31:2])
                          && ((mask_q[gi] & ld_mask) != 4'b0000);
  end

`ifdef SB_FWD_EN
  logic             fwd_found;
  logic [PTR_W-1:0] fwd_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [31:0]      fwd_shifted;
  logic [31:0]      lane_bits;

  // Youngest overlapping entry: scan back from tail-1 with wrap.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = tail_q - PTR_W'(k + 1);
      if (!fwd_found && overlap_vec[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    case (op_q[fwd_idx])
      OP_HALF: fwd_shifted = {16'h0, data_q[fwd_idx][15:0]} << (addr_q[fwd_idx][1] ? 16 : 0);
      OP_BITE: fwd_shifted = {24'h0, data_q[fwd_idx][7:0]} << {addr_q[fwd_idx][1:0], 3'b000};
      default: fwd_shifted = data_q[fwd_idx];
    endcase
  end

  assign lane_bits = {{8{ld_mask[3]}}, {8{ld_mask[2]}}, {8{ld_mask[1]}}, {8{ld_mask[0]}}};
  // Only a full cover forwards; a partial cover must wait for DM.
  assign hit = sb.ld_valid && fwd_found && ((mask_q[fwd_idx] & ld_mask) == ld_mask);
  assign sb.ld_fwd_data = hit ? (fwd_shifted & lane_bits) : 32'h0;
`else
  assign hit            = 1'b0;
  assign sb.ld_fwd_data = 32'h0;
`endif

  assign sb.ld_hit   = hit;
  assign sb.ld_stall = sb.ld_valid && (overlap_vec != '0) && !hit;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    op_d    = op_q;
    mask_d  = mask_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    // push never targets the head slot being popped: that would need a full buffer.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = sb.st_addr;
      data_d[tail_q]  = sb.st_data;
      pc_d[tail_q]    = sb.st_pc;
      op_d[tail_q]    = sb.st_op;
      mask_d[tail_q]  = st_mask;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: every read is qualified by its valid bit.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
    op_q   <= op_d;
    mask_q <= mask_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed and random stimulus for store_buffer, checked every cycle against
//   a queue-based model of the pending stores. Define SB_FWD_EN for the
//   forwarding build.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [2:0] WORD = 3'd0;
  localparam logic [2:0] HALF = 3'd1;
  localparam logic [2:0] BITE = 3'd2;
  localparam logic [2:0] BAD  = 3'b111;
`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  store_buffer_if #(.PTR_W(2)) sb ();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic [2:0]  op;
  } st_t;

  st_t q[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mmask(input logic [2:0] op, input logic [1:0] a);
    if (op == WORD) return 4'b1111;
    if (op == HALF) return a[1] ? 4'b1100 : 4'b0011;
    if (op == BITE) return 4'b0001 << a;
    return 4'b0000;
  endfunction

  // Expected load response from the list of pending stores.
  function automatic void ld_model(output logic stall, output logic hit, output logic [31:0] fwd);
    logic [3:0]  lm;
    logic [3:0]  em;
    logic [31:0] d;
    bit          ovl;
    int          y;
    int          base;
    lm = mmask(sb.ld_op, sb.ld_addr[1:0]);
    ovl = 1'b0;
    y = -1;
    hit = 1'b0;
    fwd = 32'h0;
    for (int j = q.size() - 1; j >= 0; j--) begin
      em = mmask(q[j].op, q[j].addr[1:0]);
      if (q[j].addr[31:2] == sb.ld_addr[31:2] && (em & lm) != 4'b0000) begin
        ovl = 1'b1;
        if (y < 0) y = j;
      end
    end
    if (FWD && sb.ld_valid && y >= 0) begin
      em = mmask(q[y].op, q[y].addr[1:0]);
      if ((em & lm) == lm) begin
        hit = 1'b1;
        d = q[y].data;
        if (q[y].op == WORD) base = 0;
        else if (q[y].op == HALF) base = q[y].addr[1] ? 2 : 0;
        else base = int'(q[y].addr[1:0]);
        for (int b = 0; b < 4; b++)
          if (lm[b]) fwd[8*b +: 8] = d[8*(b-base) +: 8];
      end
    end
    stall = sb.ld_valid && ovl && !hit;
  endfunction

  task automatic idle();
    sb.st_valid = 1'b0;
    sb.st_addr  = 32'h0;
    sb.st_data  = 32'h0;
    sb.st_op    = WORD;
    sb.st_pc    = 32'h0;
    sb.ld_valid = 1'b0;
    sb.ld_addr  = 32'h0;
    sb.ld_op    = WORD;
  endtask

  task automatic set_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    sb.st_op    = op;
    sb.st_pc    = pc_ctr;
    pc_ctr      = pc_ctr + 32'd4;
  endtask

  task automatic set_ld(input logic [31:0] a, input logic [2:0] op);
    sb.ld_valid = 1'b1;
    sb.ld_addr  = a;
    sb.ld_op    = op;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        e_stall;
    logic        e_hit;
    logic [31:0] e_fwd;
    bit          do_push;
    bit          do_pop;
    st_t         ent;
    @(negedge clk);
    check("count", 32'(sb.count), 32'(q.size()));
    check("empty", 32'(sb.empty), 32'(q.size() == 0));
    check("st_ready", 32'(sb.st_ready), 32'(q.size() < DEPTH));
    do_pop = (q.size() > 0) && !sb.dm_busy;
    check("dm_wr", 32'(sb.dm_wr), 32'(do_pop));
    if (do_pop) begin
      check("dm_addr", sb.dm_addr, q[0].addr);
      check("dm_wd", sb.dm_wd, q[0].data);
      check("dm_op", 32'(sb.dm_op), 32'(q[0].op));
      check("dm_pc", sb.dm_pc, q[0].pc);
      $display("%0t dm write addr=%08h data=%08h op=%0d pc=%08h", $time,
               sb.dm_addr, sb.dm_wd, sb.dm_op, sb.dm_pc);
    end
    ld_model(e_stall, e_hit, e_fwd);
    check("ld_stall", 32'(sb.ld_stall), 32'(e_stall));
    check("ld_hit", 32'(sb.ld_hit), 32'(e_hit));
    check("ld_fwd_data", sb.ld_fwd_data, e_fwd);
    do_push = sb.st_valid && (q.size() < DEPTH) && (mmask(sb.st_op, sb.st_addr[1:0]) != 4'b0000);
    ent = '{addr: sb.st_addr, data: sb.st_data, pc: sb.st_pc, op: sb.st_op};
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(ent);
    #1;
  endtask

  initial begin
    int r;
    idle();
    sb.dm_busy = 1'b0;

    // Reset values
    #3;
    check("rst_st_ready", 32'(sb.st_ready), 32'd1);
    check("rst_dm_wr", 32'(sb.dm_wr), 32'd0);
    check("rst_ld_stall", 32'(sb.ld_stall), 32'd0);
    check("rst_ld_hit", 32'(sb.ld_hit), 32'd0);
    check("rst_empty", 32'(sb.empty), 32'd1);
    check("rst_count", 32'(sb.count), 32'd0);
    check("rst_dm_addr", sb.dm_addr, 32'h0);
    check("rst_dm_wd", sb.dm_wd, 32'h0);
    check("rst_dm_op", 32'(sb.dm_op), 32'h0);
    check("rst_dm_pc", sb.dm_pc, 32'h0);
    check("rst_fwd", sb.ld_fwd_data, 32'h0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with three pending entries
    sb.dm_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_st(32'h40 + 32'(4*i), 32'hA0 + 32'(i), WORD);
      cycle();
    end
    idle();
    sb.dm_busy = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_count", 32'(sb.count), 32'd0);
    check("midrst_empty", 32'(sb.empty), 32'd1);
    check("midrst_dm_wr", 32'(sb.dm_wr), 32'd0);
    q.delete();
    #3 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle();

    // Fill to DEPTH, hold a fifth store, then drain in order
    sb.dm_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_st(32'(4*i), 32'h1111_0000 + 32'(i), WORD);
      cycle();
    end
    set_st(32'h10, 32'h5555_5555, WORD);
    #2;
    check("full_st_ready", 32'(sb.st_ready), 32'd0);
    check("full_count", 32'(sb.count), 32'd4);
    cycle();
    check("held_count", 32'(sb.count), 32'd4);
    sb.dm_busy = 1'b0;
    cycle();
    idle();
    for (int i = 0; i < 6; i++) cycle();

    // Byte-lane overlap
    sb.dm_busy = 1'b1;
    set_st(32'h103, 32'h12, BITE);
    cycle();
    idle();
    set_ld(32'h100, HALF);
    #2;
    check("lh_no_overlap", 32'(sb.ld_stall), 32'd0);
    cycle();
    set_ld(32'h103, BITE);
    #2;
    check("lb_overlap", 32'(sb.ld_stall), 32'(!FWD));
    cycle();
    sb.dm_busy = 1'b0;
    cycle();
    cycle();
    idle();

    // Push and pop together at count=2, then six back-to-back stores
    sb.dm_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_st(32'h200 + 32'(4*i), 32'hB0 + 32'(i), WORD);
      cycle();
    end
    sb.dm_busy = 1'b0;
    set_st(32'h208, 32'hB2, WORD);
    cycle();
    check("pushpop_count", 32'(sb.count), 32'd2);
    for (int i = 0; i < 6; i++) begin
      set_st(32'h300 + 32'(4*i), 32'hC0 + 32'(i), HALF);
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Forwarding from the youngest overlapping entry
    sb.dm_busy = 1'b1;
    set_st(32'h20, 32'hAABBCCDD, WORD);
    cycle();
    set_st(32'h22, 32'h1122, HALF);
    cycle();
    idle();
    set_ld(32'h22, HALF);
    #2;
    check("lh_fwd_hit", 32'(sb.ld_hit), 32'(FWD));
    check("lh_fwd_data", sb.ld_fwd_data, FWD ? 32'h1122_0000 : 32'h0);
    check("lh_fwd_stall", 32'(sb.ld_stall), 32'(!FWD));
    cycle();
    set_ld(32'h20, WORD);
    #2;
    check("lw_partial_stall", 32'(sb.ld_stall), 32'd1);
    check("lw_partial_hit", 32'(sb.ld_hit), 32'd0);
    cycle();
    idle();
    sb.dm_busy = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Unknown op is handshaken and dropped
    set_st(32'h400, 32'hDEAD, BAD);
    #2;
    check("bad_st_ready", 32'(sb.st_ready), 32'd1);
    cycle();
    check("bad_count", 32'(sb.count), 32'd0);
    idle();
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 9));
        set_st(32'h100 + 32'($urandom_range(0, 15)), $urandom,
               (r < 4) ? WORD : (r < 7) ? HALF : (r < 9) ? BITE : BAD);
      end
      if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 2));
        set_ld(32'h100 + 32'($urandom_range(0, 15)), (r == 0) ? WORD : (r == 1) ? HALF : BITE);
      end
      sb.dm_busy = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle();
    sb.dm_busy = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
